bcd_scan_driver: RTL and testbench

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

---
 rtl/bcd_scan_driver.sv | 103 ++++++++++
 tb/tb_bcd_scan_driver.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_driver.sv
// rtl/bcd_scan_driver.sv - four-digit BCD counter driving a time-multiplexed seven-segment display
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_scan_driver #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_en,
  input  logic        clear,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic [15:0] value,
  output logic        carry
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [15:0]   r_value;
  logic          r_carry;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_index;

  logic [15:0]   w_value_inc;
  logic          w_wrap;
  logic [3:0]    w_sel_nib;
  logic          w_blank;

  // Decimal ripple increment; a nibble at 9 (or above) rolls to 0 and carries.
  always_comb begin
    logic w_cin;
    w_cin       = 1'b1;
    w_value_inc = r_value;
    for (int i = 0; i < 4; i++) begin
      if (w_cin) begin
        if (r_value[4*i +: 4] >= 4'd9) begin
          w_value_inc[4*i +: 4] = 4'd0;
        end else begin
          w_value_inc[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
          w_cin                 = 1'b0;
        end
      end
    end
  end

  assign w_wrap = (r_value == 16'h9999);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= 16'h0000;
      r_carry <= 1'b0;
    end else if (clear) begin
      r_value <= 16'h0000;
      r_carry <= 1'b0;
    end else if (count_en) begin
      r_value <= w_value_inc;
      r_carry <= w_wrap;
    end else begin
      r_carry <= 1'b0;
    end
  end

  // Scan timing is free-running; only reset touches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre   <= '0;
      r_index <= 2'd0;
    end else if (r_pre == PRE_LAST) begin
      r_pre   <= '0;
      r_index <= r_index + 2'd1;
    end else begin
      r_pre   <= r_pre + 1'b1;
    end
  end

  always_comb begin
    case (r_index)
      2'd0:    w_sel_nib = r_value[3:0];
      2'd1:    w_sel_nib = r_value[7:4];
      2'd2:    w_sel_nib = r_value[11:8];
      default: w_sel_nib = r_value[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    case (r_index)
      2'd0:    w_blank = 1'b0;
      2'd1:    w_blank = (r_value[15:4] == 12'h000);
      2'd2:    w_blank = (r_value[15:8] == 8'h00);
      default: w_blank = (r_value[15:12] == 4'h0);
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign an    = w_blank ? 4'b1111 : ~(4'b0001 << r_index);
  assign digit = w_blank ? 4'hF : w_sel_nib;
  assign value = r_value;
  assign carry = r_carry;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb/tb_bcd_scan_driver.sv - randomized self-checking bench for bcd_scan_driver against an arithmetic model
module tb_bcd_scan_driver;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic        count_en;
  logic        clear;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic [15:0] value;
  logic        carry;

  int n_cmp;
  int n_err;

  int m_count;
  int m_cycles;
  bit m_carry;

  bcd_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en),
    .clear    (clear),
    .digit    (digit),
    .an       (an),
    .value    (value),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int m_idx();
    return (m_cycles / SCAN_DIV) % 4;
  endfunction

  function automatic int pow10(int e);
    int p;
    p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  function automatic bit m_blank();
    bit b;
`ifdef LEADING_ZERO_BLANK_EN
    b = (m_idx() > 0) && (m_count < pow10(m_idx()));
`else
    b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] a;
    a = 4'b1111;
    if (!m_blank()) a[m_idx()] = 1'b0;
    return a;
  endfunction

  function automatic logic [3:0] exp_digit();
    if (m_blank()) return 4'hF;
    return 4'((m_count / pow10(m_idx())) % 10);
  endfunction

  // One clock edge: the model consumes the same inputs the DUT saw.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_count  = 0;
      m_carry  = 1'b0;
      m_cycles = 0;
    end else begin
      m_carry = count_en && !clear && (m_count == 9999);
      if (clear) m_count = 0;
      else if (count_en) m_count = (m_count + 1) % 10000;
      m_cycles++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; count_en = 1'b0; clear = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] scan_an [4];
    scan_an = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst = 1'b1; count_en = 1'b0; clear = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if (value !== 16'h0000 || an !== 4'b1110 || digit !== 4'h0 || carry !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: value=%h an=%b digit=%h carry=%b required 0000 1110 0 0", value, an, digit, carry);
    end
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c % 4 == 0) begin
        n_cmp++;
        if (an !== scan_an[c/4 - 1]) begin
          n_err++;
          $display("FAIL reset_scan c=%0d: an=%b required %b", c, an, scan_an[c/4 - 1]);
        end
      end
    end
  endtask

  task automatic test_count_pulses();
    do_reset();
    for (int p = 0; p < 11; p++) begin
      count_en = 1'b1; tick();
      count_en = 1'b0; tick();
      n_cmp++;
      if (value !== to_bcd(m_count) || value[3:0] > 4'd9 || value[7:4] > 4'd9) begin
        n_err++;
        $display("FAIL pulse_count p=%0d: value=%h required %h", p, value, to_bcd(m_count));
      end
      if (p == 9) begin
        n_cmp++;
        if (value !== 16'h0010) begin
          n_err++;
          $display("FAIL pulse_ten: value=%h required 0010", value);
        end
      end
    end
    n_cmp++;
    if (value !== 16'h0011) begin
      n_err++;
      $display("FAIL pulse_eleven: value=%h required 0011", value);
    end
  endtask

  task automatic test_blank();
    logic [3:0] t_dig [4];
    logic [3:0] t_an  [4];
`ifdef LEADING_ZERO_BLANK_EN
    t_dig = '{4'h2, 4'h4, 4'hF, 4'hF};
    t_an  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
`else
    t_dig = '{4'h2, 4'h4, 4'h0, 4'h0};
    t_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
    do_reset();
    count_en = 1'b1;
    repeat (42) tick();
    count_en = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      n_cmp++;
      if (value !== 16'h0042 || an !== t_an[m_idx()] || digit !== t_dig[m_idx()]) begin
        n_err++;
        $display("FAIL blank idx=%0d: value=%h an=%b digit=%h required 0042 %b %h",
                 m_idx(), value, an, digit, t_an[m_idx()], t_dig[m_idx()]);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    count_en = 1'b1;
    repeat (123) tick();
    n_cmp++;
    if (value !== 16'h0123) begin
      n_err++;
      $display("FAIL clear_load: value=%h required 0123", value);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0; count_en = 1'b0;
    n_cmp++;
    if (value !== 16'h0000 || carry !== 1'b0 || an !== exp_an() || m_cycles != 124) begin
      n_err++;
      $display("FAIL clear_with_en: value=%h carry=%b an=%b required 0000 0 %b", value, carry, an, exp_an());
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    count_en = 1'b1;
    repeat (577) tick();
    count_en = 1'b0;
    guard = 0;
    while (m_idx() != 2 && guard < 20) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (guard >= 20 || value !== 16'h0577 || an !== 4'b1011) begin
      n_err++;
      $display("FAIL reset_mid_setup: value=%h an=%b required 0577 1011", value, an);
    end
    rst = 1'b1; count_en = 1'b1;
    tick();
    rst = 1'b0; count_en = 1'b0;
    n_cmp++;
    if (value !== 16'h0000 || an !== 4'b1110 || carry !== 1'b0 || digit !== 4'h0) begin
      n_err++;
      $display("FAIL reset_mid: value=%h an=%b carry=%b digit=%h required 0000 1110 0 0", value, an, carry, digit);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      count_en = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 29) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      tick();
      n_cmp++;
      if (value !== to_bcd(m_count) || carry !== m_carry || an !== exp_an() || digit !== exp_digit()) begin
        n_err++;
        $display("FAIL random c=%0d: value=%h carry=%b an=%b digit=%h required %h %b %b %h",
                 c, value, carry, an, digit, to_bcd(m_count), m_carry, exp_an(), exp_digit());
      end
    end
    rst = 1'b0; count_en = 1'b0; clear = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    count_en = 1'b1;
    for (int lap = 0; lap < 2; lap++) begin
      for (int c = 0; c < 9999; c++) begin
        tick();
        n_cmp++;
        if (value !== to_bcd(m_count) || carry !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_load lap=%0d c=%0d: value=%h carry=%b required %h 0", lap, c, value, carry, to_bcd(m_count));
        end
      end
      n_cmp++;
      if (value !== 16'h9999) begin
        n_err++;
        $display("FAIL wrap_at_9999: value=%h required 9999", value);
      end
      if (lap == 0) begin
        tick();
        n_cmp++;
        if (value !== 16'h0000 || carry !== 1'b1) begin
          n_err++;
          $display("FAIL wrap_edge: value=%h carry=%b required 0000 1", value, carry);
        end
        count_en = 1'b0;
        tick();
        n_cmp++;
        if (value !== 16'h0000 || carry !== 1'b0) begin
          n_err++;
          $display("FAIL wrap_after: value=%h carry=%b required 0000 0", value, carry);
        end
        count_en = 1'b1;
      end
    end
    clear = 1'b1;
    tick();
    clear = 1'b0; count_en = 1'b0;
    n_cmp++;
    if (value !== 16'h0000 || carry !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_clear: value=%h carry=%b required 0000 0", value, carry);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_count = 0; m_cycles = 0; m_carry = 1'b0;
    rst = 1'b1; count_en = 1'b0; clear = 1'b0;
    test_reset();
    test_count_pulses();
    test_blank();
    test_clear();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
